// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4 - receive end of a 4:1 slot-multiplexed link.
//
// Rebuilds four parallel WIDTH-bit channels from one serial sample stream in
// which slots 0..3 repeat in order and sync marks slot 0. A complete frame is
// presented on dout_o all at once, together with a one-cycle frame_valid_o
// strobe.
//
// Optional feature macro: TDM_DEMUX_SYNC_CHECK_EN
//   defined   - missing/early sync detection, sync_err_o strobe, realign on
//               early sync, drop back to hunt on missing sync.
//   undefined - after first lock the slot counter free-runs on beats, sync is
//               ignored in lock, sync_err_o is tied 0, locked_o stays 1.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   din_i          incoming sample
//   din_valid_i    din_i carries a sample this cycle (a "beat")
//   sync_i         qualified by din_valid_i; current sample is slot 0
//   dout_o         frame, channel k at dout_o[k*WIDTH +: WIDTH]
//   frame_valid_o  one-cycle strobe, dout_o updated this cycle
//   locked_o       aligned to the slot sequence
//   sync_err_o     one-cycle strobe, sync seen at an unexpected slot

module tdm_demux_1to4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   din_i,
  input  logic               din_valid_i,
  input  logic               sync_i,
  output logic [4*WIDTH-1:0] dout_o,
  output logic               frame_valid_o,
  output logic               locked_o,
  output logic               sync_err_o
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e                     state_q;
  logic [1:0]                 slot_q;
  // Slots 0..2 are held here; slot 3 goes straight from din_i into dout_o.
  logic [2:0][WIDTH-1:0]      cap_q;
  logic [4*WIDTH-1:0]         dout_q;
  logic                       frame_valid_q;
  logic                       locked_q;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic                       sync_err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StHunt;
      slot_q        <= 2'd0;
      cap_q         <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      sync_err_q    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-armed below.
      frame_valid_q <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      sync_err_q    <= 1'b0;
`endif
      if (din_valid_i) begin
        unique case (state_q)
          StHunt: begin
            if (sync_i) begin
              cap_q[0] <= din_i;
              slot_q   <= 2'd1;
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
          StLocked: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            if (slot_q == 2'd0 && !sync_i) begin
              // Missing sync: drop partial data and hunt again.
              sync_err_q <= 1'b1;
              state_q    <= StHunt;
              locked_q   <= 1'b0;
              slot_q     <= 2'd0;
            end else if (slot_q != 2'd0 && sync_i) begin
              // Early sync: abandon the partial frame, realign on this beat.
              sync_err_q <= 1'b1;
              cap_q[0]   <= din_i;
              slot_q     <= 2'd1;
            end else
`endif
            begin
              unique case (slot_q)
                2'd0: cap_q[0] <= din_i;
                2'd1: cap_q[1] <= din_i;
                2'd2: cap_q[2] <= din_i;
                2'd3: begin
                  dout_q        <= {din_i, cap_q};
                  frame_valid_q <= 1'b1;
                end
                default: ;
              endcase
              slot_q <= slot_q + 2'd1;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign dout_o        = dout_q;
  assign frame_valid_o = frame_valid_q;
  assign locked_o      = locked_q;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign sync_err_o    = sync_err_q;
`else
  assign sync_err_o    = 1'b0;
`endif

endmodule
